// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF      = 32;
    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// slave  : the arbiter's view (serves the pipeline, drives the memory).
// master : the environment's view (pipeline requesters plus memory model).
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    // fetch port
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_ack;
    logic [DATA_W-1:0]     if_rdata;
    // data port
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_mask;
    logic                  dm_ack;
    logic [DATA_W-1:0]     dm_rdata;
    // status
    logic                  bus_err;
    logic                  stall_if;
    logic                  stall_dm;
    // memory side
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_mask;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_mask,
        output dm_ack, dm_rdata,
        output bus_err, stall_if, stall_dm,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_mask,
        input  dm_ack, dm_rdata,
        input  bus_err, stall_if, stall_dm,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Saturating counter of ISSUE cycles; expire flags the last allowed cycle.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // count while enabled, hold at the terminal value, restart on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and load/store.
// Optional build macro MEM_ARB_RR_EN selects round-robin grant instead of
// fixed dm-over-if priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned MASK_W = DATA_W / 8;

    state_t              state, state_d;
    gnt_t                gnt, pick;
    logic                err_flag;
    logic                start, done_ok, done_to;
    logic                tmr_clr, tmr_en, tmr_expire;
    logic                if_ack, dm_ack, bus_err;

    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [MASK_W-1:0]   mem_mask_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;

    mem_arb_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

`ifdef MEM_ARB_RR_EN
    gnt_t last_gnt;

    // on a tie the requester that did not win last time gets the port
    always_comb begin
        pick = GNT_IF;
        if (bus.dm_req && bus.if_req) begin
            pick = (last_gnt == GNT_DM) ? GNT_IF : GNT_DM;
        end else if (bus.dm_req) begin
            pick = GNT_DM;
        end
    end

    // remember the most recent winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= GNT_IF;
        end else if (start) begin
            last_gnt <= pick;
        end
    end
`else
    // data stage always wins: it holds the older instruction
    always_comb begin
        pick = bus.dm_req ? GNT_DM : GNT_IF;
    end
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // next state, transaction events and response strobes
    always_comb begin
        state_d = state;
        start   = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        if_ack  = 1'b0;
        dm_ack  = 1'b0;
        bus_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    start   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                if (bus.mem_ack) begin
                    done_ok = 1'b1;
                    state_d = RESP;
                end else if (tmr_expire) begin
                    done_to = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if_ack  = (gnt == GNT_IF);
                dm_ack  = (gnt == GNT_DM);
                bus_err = err_flag;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // memory command, grant, read data and error flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt         <= GNT_IF;
            err_flag    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (start) begin
                gnt       <= pick;
                mem_req_q <= 1'b1;
                err_flag  <= 1'b0;
                if (pick == GNT_DM) begin
                    mem_we_q    <= bus.dm_we;
                    mem_addr_q  <= bus.dm_addr;
                    mem_wdata_q <= bus.dm_wdata;
                    mem_mask_q  <= bus.dm_mask;
                end else begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= bus.if_addr;
                    mem_wdata_q <= '0;
                    mem_mask_q  <= '1;
                end
            end
            if (done_ok) begin
                mem_req_q <= 1'b0;
                if (gnt == GNT_DM) dm_rdata_q <= bus.mem_rdata;
                else               if_rdata_q <= bus.mem_rdata;
            end
            if (done_to) begin
                mem_req_q <= 1'b0;
                err_flag  <= 1'b1;
                if (gnt == GNT_DM) dm_rdata_q <= '0;
                else               if_rdata_q <= '0;
            end
            if (state == RESP) begin
                err_flag <= 1'b0;
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_mask  = mem_mask_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack;
    assign bus.dm_ack    = dm_ack;
    assign bus.bus_err   = bus_err;
    assign bus.stall_if  = bus.if_req & ~if_ack;
    assign bus.stall_dm  = bus.dm_req & ~dm_ack;

endmodule
